counter_bank: RTL
=================

Name: counter_bank

Overview:
Parametrised bank of NUM_CH independent event counters. It generalises the single 32-bit clear/increment counter. Additions over that counter:
- configurable width and step
- wrap or saturate mode
- per-channel parallel load
- sticky overflow flags
- registered indexed read-back port

Used for performance and event counting in the core and test harnesses.

Parameters:
NUM_CH, 4, number of counter channels (1..32)
WIDTH, 32, counter width in bits (2..64)
STEP_W, 4, width of the shared increment step input
SATURATE, 0, 0 = wrap modulo 2^WIDTH, 1 = clamp at 2^WIDTH-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
inc  input  NUM_CH  per-channel increment request
step  input  STEP_W  amount added on inc, shared by all channels
clr  input  NUM_CH  per-channel synchronous clear
load_en  input  1  parallel load strobe
load_ch  input  $clog2(NUM_CH) (min 1)  channel to load
load_val  input  WIDTH  value to load
ovf_clr  input  NUM_CH  per-channel overflow flag clear
rd_en  input  1  read request
rd_ch  input  $clog2(NUM_CH) (min 1)  channel to read
rd_data  output  WIDTH  registered read data
rd_valid  output  1  read data valid
count  output  NUM_CH*WIDTH  all counters, flattened, channel 0 in LSBs
ovf  output  NUM_CH  sticky overflow flags

Behaviour:
- Reset: rst low asynchronously forces all of the following to 0: count, ovf, rd_data, rd_valid. Registers release on the first clk edge with rst high.
- Per-channel update priority, evaluated each rising edge:
  - clr[i] takes precedence. count[i] <= 0.
  - Otherwise, load_en && load_ch==i gives count[i] <= load_val.
  - Otherwise, inc[i] gives count[i] <= count[i] + step.
  - Otherwise count[i] holds.
- step==0 with inc[i] high leaves count unchanged and never sets ovf.
- Increment arithmetic is performed in WIDTH+1 bits. Carry out = overflow event.
  - SATURATE=0: count[i] <= sum[WIDTH-1:0] (wrap).
  - SATURATE=1: on carry, count[i] <= all ones. Otherwise count[i] <= sum.
- ovf[i] is set on the edge where an overflow event occurs.
  - Set has priority over ovf_clr[i] in the same cycle.
  - ovf_clr[i] alone clears the flag.
  - clr[i] and load do not affect ovf.
  - In SATURATE=1, an inc while already at max with step>0 is an overflow event, so it sets ovf again.
- load_ch >= NUM_CH: the load is ignored and no channel changes.
- Simultaneous clr[i] and load to channel i: clr wins, so count=0.
- count output is the register value, zero-latency combinational view of state.
- Read port, fixed 1-cycle latency:
  - rd_en sampled at edge N makes rd_valid=1 for the cycle after edge N.
  - rd_data = count[rd_ch] value held *before* edge N's update (pre-update snapshot).
  - rd_ch >= NUM_CH returns rd_data=0 with rd_valid=1.
  - rd_en low gives rd_valid=0. rd_data holds its last value.
  - Back-to-back reads are allowed every cycle.
- Reset mid-operation: all state is lost immediately. A pending read is dropped (rd_valid=0).

Decomposition:
- Package counter_bank_pkg holds:
  - function idx_w(n) returning max(1,$clog2(n))
  - typedef enum {CNT_WRAP, CNT_SAT} cnt_mode_e, mapped to SATURATE
  - localparam defaults for NUM_CH, WIDTH, STEP_W
- Sub-module counter_chan: one channel, parameters WIDTH/STEP_W/SATURATE.
  - Inputs: clr, load, load_val, inc, step, ovf_clr.
  - Outputs: count, ovf.
- The top instantiates NUM_CH channels via generate, decodes load_ch, and implements the read mux and register.

Test Plan:
- Reset: hold rst=0 with inc all ones -> count=0, ovf=0, rd_valid=0. Release rst, then one cycle inc[0]=1, step=1 -> count[0]=1.
- Wrap, SATURATE=0, WIDTH=8: load ch1=0xFE, then inc[1] with step=3 -> count[1]=0x01, ovf[1]=1. Same-cycle ovf_clr[1]=1 during the overflowing inc -> ovf[1] still 1. Next cycle ovf_clr[1]=1 -> ovf[1]=0.
- Saturate, SATURATE=1, WIDTH=8: load ch2=0xFD, inc with step=5 -> count[2]=0xFF, ovf[2]=1. Further incs -> stays 0xFF.
- Priority: same cycle clr[3]=1, load_ch=3 with load_val=0x55, inc[3]=1 -> count[3]=0. Next cycle load only -> 0x55. load_ch=NUM_CH -> no change on any channel.
- Read: count[0]=7 and inc[0] with step=1 in the same cycle as rd_en with rd_ch=0 -> next cycle rd_valid=1, rd_data=7, count[0]=8. rd_ch=NUM_CH -> rd_data=0, rd_valid=1.
- Async reset mid-run: drop rst between edges while counters are nonzero and a read is pending -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg
// Shared definitions for the counter bank.
// Provides:
//   - default sizes for the bank
//   - the wrap/saturate mode enum
//   - idx_w(): the width of a channel index, never less than one bit
//   - mode_of(): maps the integer SATURATE parameter onto the mode enum
package counter_bank_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STEP_W = 4;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  // A single-channel bank still needs a one-bit index port.
  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic cnt_mode_e mode_of(input int saturate);
    return (saturate != 0) ? CNT_SAT : CNT_WRAP;
  endfunction

endpackage

// File: rtl/counter_chan.sv
// counter_chan
// One event-counter channel with clear, load, step increment and a sticky
// overflow flag.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   clr      synchronous clear (highest priority)
//   load     parallel load strobe for this channel
//   load_val value to load
//   inc      increment request
//   step     amount added on inc
//   ovf_clr  clear of the sticky overflow flag
//   count    current counter value
//   ovf      sticky overflow flag
module counter_chan
  import counter_bank_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int STEP_W   = DEF_STEP_W,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              inc,
  input  logic [STEP_W-1:0] step,
  input  logic              ovf_clr,
  output logic [WIDTH-1:0]  count,
  output logic              ovf
);

  localparam cnt_mode_e MODE = mode_of(SATURATE);

  // The sum is wide enough that neither operand is truncated, even when
  // the step input is wider than the counter itself.
  localparam int SUM_W = (STEP_W > WIDTH) ? STEP_W + 1 : WIDTH + 1;

  logic [SUM_W-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] inc_val;
  logic             inc_ovf;

  // Increment datapath: any bit above the counter width is a carry out,
  // which is the overflow event. An overflow only counts when the increment
  // actually wins the update priority over clear and load.
  always_comb begin
    sum     = {{(SUM_W-WIDTH){1'b0}}, count} + {{(SUM_W-STEP_W){1'b0}}, step};
    carry   = |sum[SUM_W-1:WIDTH];
    inc_val = sum[WIDTH-1:0];
    if (carry && (MODE == CNT_SAT)) begin
      inc_val = '1;
    end
    inc_ovf = inc && !clr && !load && carry;
  end

  // Counter register with clear > load > increment priority. The flag set
  // wins over a same-cycle flag clear so an overflow is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (clr) begin
        count <= '0;
      end else if (load) begin
        count <= load_val;
      end else if (inc) begin
        count <= inc_val;
      end

      if (inc_ovf) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/counter_bank.sv
// counter_bank
// Bank of NUM_CH independent event counters with a registered indexed
// read-back port.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   inc      per-channel increment request
//   step     increment amount shared by all channels
//   clr      per-channel synchronous clear
//   load_en  parallel load strobe
//   load_ch  channel to load (out-of-range index loads nothing)
//   load_val value to load
//   ovf_clr  per-channel overflow flag clear
//   rd_en    read request
//   rd_ch    channel to read (out-of-range index reads zero)
//   rd_data  registered read data, pre-update snapshot of the channel
//   rd_valid read data valid, one cycle after rd_en
//   count    all counters flattened, channel 0 in the LSBs
//   ovf      sticky overflow flags
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int STEP_W   = DEF_STEP_W,
  parameter int SATURATE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          inc,
  input  logic [STEP_W-1:0]          step,
  input  logic [NUM_CH-1:0]          clr,
  input  logic                       load_en,
  input  logic [idx_w(NUM_CH)-1:0]   load_ch,
  input  logic [WIDTH-1:0]           load_val,
  input  logic [NUM_CH-1:0]          ovf_clr,
  input  logic                       rd_en,
  input  logic [idx_w(NUM_CH)-1:0]   rd_ch,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [NUM_CH*WIDTH-1:0]    count,
  output logic [NUM_CH-1:0]          ovf
);

  localparam int IDX_W = idx_w(NUM_CH);

  logic [WIDTH-1:0] chan_count [NUM_CH];
  logic [WIDTH-1:0] rd_sel;

  // One channel per generate iteration. The load decode compares against
  // every legal index only, so an out-of-range load_ch selects nothing.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    logic load_sel;

    assign load_sel = load_en && (load_ch == IDX_W'(g));

    counter_chan #(
      .WIDTH    (WIDTH),
      .STEP_W   (STEP_W),
      .SATURATE (SATURATE)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr[g]),
      .load     (load_sel),
      .load_val (load_val),
      .inc      (inc[g]),
      .step     (step),
      .ovf_clr  (ovf_clr[g]),
      .count    (chan_count[g]),
      .ovf      (ovf[g])
    );

    assign count[g*WIDTH +: WIDTH] = chan_count[g];
  end

  // Read mux from the current register values, so the registered result is
  // the value held before the edge that captures it. Out-of-range reads 0.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == IDX_W'(i)) begin
        rd_sel = chan_count[i];
      end
    end
  end

  // Read register: valid follows the request one cycle later, data is only
  // refreshed on a request and otherwise holds its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_sel;
      end
    end
  end

endmodule
